// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the two-client RAM port controller.
package ram_ctrl_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef logic client_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last winner loses the next tie.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    client_t last_grant;

    // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt = last_grant ? 2'b01 : 2'b10;
        else
            gnt = req;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= gnt[1];
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// Clears the RAM after reset, then arbitrates two clients onto its single port
// and steers registered read data back to the client that issued the read.
module ram_port_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,

    output logic              init_done
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    client_t           winner;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              tag_valid;
    client_t           tag_owner;

    assign req = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    // A grant only exists for a valid request, so ready doubles as the handshake.
    assign req0_ready = init_done & gnt[0];
    assign req1_ready = init_done & gnt[1];
    assign accept     = req0_ready | req1_ready;
    assign winner     = gnt[1];

    assign sel_wr    = winner ? req1_wr    : req0_wr;
    assign sel_addr  = winner ? req1_addr  : req0_addr;
    assign sel_wdata = winner ? req1_wdata : req0_wdata;

    assign rsp0_rdata = ram_dout;
    assign rsp1_rdata = ram_dout;

    // NOTE: the RAM array itself is never reset; the INIT sweep clears it by writing every location.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            cnt        <= '0;
            init_done  <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            tag_valid  <= 1'b0;
            tag_owner  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            // The tag follows the command by one edge, matching the RAM's registered read.
            rsp0_valid <= tag_valid & (tag_owner == 1'b0);
            rsp1_valid <= tag_valid & (tag_owner == 1'b1);
            tag_valid  <= 1'b0;

            case (state)
                INIT: begin
                    ram_wr   <= 1'b1;
                    ram_addr <= cnt;
                    ram_din  <= INIT_VAL;
                    cnt      <= cnt + 1'b1;
                    if (&cnt) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        ram_wr    <= sel_wr;
                        ram_addr  <= sel_addr;
                        ram_din   <= sel_wdata;
                        tag_valid <= ~sel_wr;
                        tag_owner <= winner;
                    end else begin
                        ram_wr <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl driving a behavioural 16x8 single-port RAM.
module tb_ram_port_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req0_wr;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_wr;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              init_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .init_done  (init_done)
    );

    // Single-port RAM: registered read, write wins, dout holds on write cycles.
    logic [DATA_W-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
        ram_dout = 8'hFF;
    end
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        else        ram_dout      <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    // Sweep with both clients requesting: ready must stay low until init_done.
    task automatic init_sweep(input string tag);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
            check({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
            step();
            check({tag, "_wr"},   32'(ram_wr),    32'd1);
            check({tag, "_addr"}, 32'(ram_addr),  32'(i));
            check({tag, "_din"},  32'(ram_din),   32'd0);
            check({tag, "_done"}, 32'(init_done), (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #12;
        check("rst_ram_wr",   32'(ram_wr),     32'd0);
        check("rst_ram_addr", 32'(ram_addr),   32'd0);
        check("rst_ram_din",  32'(ram_din),    32'd0);
        check("rst_rsp0",     32'(rsp0_valid), 32'd0);
        check("rst_rsp1",     32'(rsp1_valid), 32'd0);
        check("rst_done",     32'(init_done),  32'd0);
        check("rst_rdy0",     32'(req0_ready), 32'd0);
        check("rst_rdy1",     32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        init_sweep("init");
        step();
        check("idle_wr",   32'(ram_wr),   32'd0);
        check("idle_addr", 32'(ram_addr), 32'd15);

        // Client 0: write 3 = A5, then read 3 on the next cycle.
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 4'd3; req0_wdata = 8'hA5;
        #1;
        check("w3_rdy0", 32'(req0_ready), 32'd1);
        check("w3_rdy1", 32'(req1_ready), 32'd0);
        step();
        check("w3_wr",   32'(ram_wr),   32'd1);
        check("w3_addr", 32'(ram_addr), 32'd3);
        check("w3_din",  32'(ram_din),  32'hA5);
        req0_wr = 1'b0;
        #1;
        check("r3_rdy0", 32'(req0_ready), 32'd1);
        step();
        check("r3_wr",      32'(ram_wr),     32'd0);
        check("r3_rsp0_e0", 32'(rsp0_valid), 32'd0);
        idle_inputs();
        step();
        check("r3_rsp0",   32'(rsp0_valid), 32'd1);
        check("r3_rdata0", 32'(rsp0_rdata), 32'hA5);
        check("r3_rsp1",   32'(rsp1_valid), 32'd0);
        step();
        check("r3_rsp0_off", 32'(rsp0_valid), 32'd0);

        // Tie with last_grant=0: client 1 write 7 = 3C wins, client 0 read 7 follows.
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 4'd7; req1_wdata = 8'h3C;
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 4'd7;
        #1;
        check("t7_rdy1", 32'(req1_ready), 32'd1);
        check("t7_rdy0", 32'(req0_ready), 32'd0);
        step();
        req1_valid = 1'b0;
        #1;
        check("t7_rdy0_next", 32'(req0_ready), 32'd1);
        step();
        idle_inputs();
        check("t7_rsp0_e1", 32'(rsp0_valid), 32'd0);
        step();
        check("t7_rsp0",   32'(rsp0_valid), 32'd1);
        check("t7_rdata0", 32'(rsp0_rdata), 32'h3C);
        check("t7_rsp1",   32'(rsp1_valid), 32'd0);

        // Untouched address reads back the init value.
        req0_valid = 1'b1; req0_addr = 4'd9;
        step();
        idle_inputs();
        step();
        check("r9_rsp0",   32'(rsp0_valid), 32'd1);
        check("r9_rdata0", 32'(rsp0_rdata), 32'h00);

        // Seed addr 1 and 2 so responses are distinguishable; leaves last_grant=1.
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 4'd1; req0_wdata = 8'h11;
        step();
        idle_inputs();
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 4'd2; req1_wdata = 8'h22;
        step();
        idle_inputs();
        step();

        // Both clients hold reads: grants 0,1,0,1, responses follow by one cycle.
        req0_valid = 1'b1; req0_addr = 4'd1;
        req1_valid = 1'b1; req1_addr = 4'd2;
        #1;
        check("alt_a_rdy0", 32'(req0_ready), 32'd1);
        check("alt_a_rdy1", 32'(req1_ready), 32'd0);
        step();
        check("alt_b_rdy1", 32'(req1_ready), 32'd1);
        check("alt_b_rdy0", 32'(req0_ready), 32'd0);
        check("alt_b_rsp0", 32'(rsp0_valid), 32'd0);
        step();
        check("alt_c_rdy0",  32'(req0_ready), 32'd1);
        check("alt_c_rsp0",  32'(rsp0_valid), 32'd1);
        check("alt_c_data0", 32'(rsp0_rdata), 32'h11);
        check("alt_c_rsp1",  32'(rsp1_valid), 32'd0);
        step();
        check("alt_d_rdy1",  32'(req1_ready), 32'd1);
        check("alt_d_rsp1",  32'(rsp1_valid), 32'd1);
        check("alt_d_data1", 32'(rsp1_rdata), 32'h22);
        check("alt_d_rsp0",  32'(rsp0_valid), 32'd0);
        step();
        idle_inputs();
        check("alt_e_rsp0",  32'(rsp0_valid), 32'd1);
        check("alt_e_data0", 32'(rsp0_rdata), 32'h11);
        step();
        check("alt_f_rsp1",  32'(rsp1_valid), 32'd1);
        check("alt_f_data1", 32'(rsp1_rdata), 32'h22);
        check("alt_f_rsp0",  32'(rsp0_valid), 32'd0);
        step();
        check("alt_g_rsp1",  32'(rsp1_valid), 32'd0);

        // Reset right after a read is accepted: its response must never appear.
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 4'd3;
        step();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("mrst_rsp0", 32'(rsp0_valid), 32'd0);
        check("mrst_done", 32'(init_done),  32'd0);
        check("mrst_wr",   32'(ram_wr),     32'd0);
        step();
        check("mrst_rsp0_hold", 32'(rsp0_valid), 32'd0);
        step();
        rst_n = 1'b1;
        init_sweep("reinit");
        check("reinit_rsp0", 32'(rsp0_valid), 32'd0);

        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 4'd3;
        step();
        idle_inputs();
        step();
        check("post_rsp0",   32'(rsp0_valid), 32'd1);
        check("post_rdata0", 32'(rsp0_rdata), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
